// File: rtl/multicycle_control.sv
// Multicycle RV32I(M) control unit: FETCH/DECODE/EXECUTE/MEM/WB/TRAP sequencer with
// combinational strobes, held ALU controls, optional data-memory timeout and retire counter.
module multicycle_control #(
  parameter int unsigned ENABLE_M    = 0,
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             trap_clear,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic             jump,
  output logic [1:0]       alu_src,
  output logic [4:0]       alu_op,
  output logic [1:0]       reg_write_src,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExecute = 3'd2,
    StMem     = 3'd3,
    StWb      = 3'd4,
    StTrap    = 3'd5
  } state_e;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Mul  = 7'b0000001;

  localparam logic [1:0] CauseIllegal = 2'b01;
  localparam logic [1:0] CauseTimeout = 2'b10;

  localparam logic [1:0] SrcReg = 2'b00;
  localparam logic [1:0] SrcImm = 2'b01;
  localparam logic [1:0] SrcPc  = 2'b10;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b1000;
  localparam logic [3:0] AluSlt  = 4'b0010;
  localparam logic [3:0] AluSltu = 4'b0011;

  localparam bit EnM = (ENABLE_M != 0);

  // Counter only needs to reach MEM_TIMEOUT-1; the trap fires on the cycle it would hit the limit.
  localparam int unsigned    WaitW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e             state_q;
  logic [6:0]         opcode_q;
  logic [2:0]         funct3_q;
  logic [6:0]         funct7_q;
  logic [WaitW-1:0]   wait_q;
  logic [1:0]         trap_cause_q;
  logic [CNT_W-1:0]   retired_q;

  logic               legal;
  logic               is_load;
  logic               is_store;
  logic               is_branch;
  logic               is_link;
  logic               timeout_hit;
  logic [1:0]         alu_src_dec;
  logic [4:0]         alu_op_dec;
  logic [1:0]         rws_dec;

  // Only opcode/funct3/funct7 steer control; the register and immediate fields go to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  assign is_load     = (opcode_q == OpLoad);
  assign is_store    = (opcode_q == OpStore);
  assign is_branch   = (opcode_q == OpBranch);
  assign is_link     = (opcode_q == OpJal) || (opcode_q == OpJalr);
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WaitLast);

  always_comb begin
    legal = 1'b0;
    case (opcode_q)
      OpReg: begin
        legal = (funct7_q == F7Base) ||
                ((funct7_q == F7Alt) && ((funct3_q == 3'b000) || (funct3_q == 3'b101))) ||
                (EnM && (funct7_q == F7Mul));
      end
      OpImm: begin
        if (funct3_q == 3'b001) begin
          legal = (funct7_q == F7Base);
        end else if (funct3_q == 3'b101) begin
          legal = (funct7_q == F7Base) || (funct7_q == F7Alt);
        end else begin
          legal = 1'b1;
        end
      end
      OpLoad:                 legal = !(funct3_q inside {3'b011, 3'b110, 3'b111});
      OpStore:                legal = (funct3_q <= 3'b010);
      OpBranch:               legal = !(funct3_q inside {3'b010, 3'b011});
      OpJalr:                 legal = (funct3_q == 3'b000);
      OpJal, OpLui, OpAuipc:  legal = 1'b1;
      default:                legal = 1'b0;
    endcase
  end

  // funct7[5] selects SUB/SRA; for I-type only SRAI uses it, other immediates reuse those bits.
  always_comb begin
    alu_src_dec = SrcReg;
    alu_op_dec  = 5'b00000;
    rws_dec     = 2'b00;
    case (opcode_q)
      OpReg: begin
        if (funct7_q == F7Mul) begin
          alu_op_dec = {2'b10, funct3_q};
        end else begin
          alu_op_dec = {1'b0, funct7_q[5] & ((funct3_q == 3'b000) || (funct3_q == 3'b101)),
                        funct3_q};
        end
      end
      OpImm: begin
        alu_src_dec = SrcImm;
        alu_op_dec  = {1'b0, funct7_q[5] & (funct3_q == 3'b101), funct3_q};
      end
      OpLoad: begin
        alu_src_dec = SrcImm;
        alu_op_dec  = {1'b0, AluAdd};
        rws_dec     = 2'b01;
      end
      OpStore: begin
        alu_src_dec = SrcImm;
        alu_op_dec  = {1'b0, AluAdd};
      end
      OpJalr: begin
        alu_src_dec = SrcImm;
        alu_op_dec  = {1'b0, AluAdd};
        rws_dec     = 2'b10;
      end
      OpJal: begin
        alu_src_dec = SrcPc;
        alu_op_dec  = {1'b0, AluAdd};
        rws_dec     = 2'b10;
      end
      OpLui: begin
        alu_src_dec = SrcImm;
        alu_op_dec  = {1'b0, AluAdd};
        rws_dec     = 2'b11;
      end
      OpAuipc: begin
        alu_src_dec = SrcPc;
        alu_op_dec  = {1'b0, AluAdd};
      end
      OpBranch: begin
        if (!funct3_q[2]) begin
          alu_op_dec = {1'b0, AluSub};
        end else if (!funct3_q[1]) begin
          alu_op_dec = {1'b0, AluSlt};
        end else begin
          alu_op_dec = {1'b0, AluSltu};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFetch;
      opcode_q     <= '0;
      funct3_q     <= '0;
      funct7_q     <= '0;
      wait_q       <= '0;
      trap_cause_q <= 2'b00;
      retired_q    <= '0;
    end else begin
      if (pc_write) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      case (state_q)
        StFetch: begin
          if (imem_ready) begin
            opcode_q <= instr[6:0];
            funct3_q <= instr[14:12];
            funct7_q <= instr[31:25];
            state_q  <= StDecode;
          end
        end
        StDecode: begin
          if (legal) begin
            state_q <= StExecute;
          end else begin
            state_q      <= StTrap;
            trap_cause_q <= CauseIllegal;
          end
        end
        StExecute: begin
          if (is_load || is_store) begin
            state_q <= StMem;
            wait_q  <= '0;
          end else if (is_branch) begin
            state_q <= StFetch;
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          if (dmem_ready) begin
            state_q <= is_load ? StWb : StFetch;
          end else if (timeout_hit) begin
            state_q      <= StTrap;
            trap_cause_q <= CauseTimeout;
          end else if (MEM_TIMEOUT != 0) begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StWb: state_q <= StFetch;
        StTrap: begin
          if (trap_clear) begin
            state_q      <= StFetch;
            trap_cause_q <= 2'b00;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  // Strobes are gated by rst so nothing (not even imem_req) leaks out while reset is held.
  always_comb begin
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    branch        = 1'b0;
    jump          = 1'b0;
    alu_src       = 2'b00;
    alu_op        = 5'b00000;
    reg_write_src = 2'b00;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
        end
        StExecute: begin
          alu_src = alu_src_dec;
          alu_op  = alu_op_dec;
          if (is_branch) begin
            branch   = 1'b1;
            pc_write = 1'b1;
          end
        end
        StMem: begin
          alu_src   = alu_src_dec;
          alu_op    = alu_op_dec;
          mem_read  = is_load;
          mem_write = is_store;
          pc_write  = is_store & dmem_ready;
        end
        StWb: begin
          alu_src       = alu_src_dec;
          alu_op        = alu_op_dec;
          reg_write     = 1'b1;
          pc_write      = 1'b1;
          reg_write_src = rws_dec;
          jump          = is_link;
        end
        default: ;
      endcase
    end
  end

  assign trap       = (state_q == StTrap);
  assign trap_cause = trap_cause_q;
  assign state      = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, reset corner sequence and random
// instruction stream against a per-instruction expected-trace model.
module tb_multicycle_control;

  localparam int unsigned CntWA = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = '0;
  logic        imem_ready_v = 1'b0;
  logic        dmem_ready_v = 1'b0;
  logic        trap_clear_v = 1'b0;
  int          sel = 0;  // 0: ENABLE_M=1, MEM_TIMEOUT=4, CNT_W=4; 1: ENABLE_M=0, MEM_TIMEOUT=0

  logic a_ir, a_dr, a_tc, b_ir, b_dr, b_tc;
  assign a_ir = imem_ready_v & (sel == 0);
  assign a_dr = dmem_ready_v & (sel == 0);
  assign a_tc = trap_clear_v & (sel == 0);
  assign b_ir = imem_ready_v & (sel == 1);
  assign b_dr = dmem_ready_v & (sel == 1);
  assign b_tc = trap_clear_v & (sel == 1);

  logic a_imem_req, a_ir_write, a_pc_write, a_reg_write, a_mem_read, a_mem_write, a_branch;
  logic a_jump, a_trap;
  logic [1:0] a_alu_src, a_reg_write_src, a_trap_cause;
  logic [4:0] a_alu_op;
  logic [2:0] a_state;
  logic [CntWA-1:0] a_retired;
  logic b_imem_req, b_ir_write, b_pc_write, b_reg_write, b_mem_read, b_mem_write, b_branch;
  logic b_jump, b_trap;
  logic [1:0] b_alu_src, b_reg_write_src, b_trap_cause;
  logic [4:0] b_alu_op;
  logic [2:0] b_state;
  logic [31:0] b_retired;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       trap;
    logic [1:0] trap_cause;
    logic [2:0] state;
    logic [1:0] alu_src;
    logic [4:0] alu_op;
    logic [1:0] rws;
  } obs_t;

  obs_t a_obs, b_obs;
  assign a_obs = {a_imem_req, a_ir_write, a_pc_write, a_reg_write, a_mem_read, a_mem_write,
                  a_branch, a_jump, a_trap, a_trap_cause, a_state, a_alu_src, a_alu_op,
                  a_reg_write_src};
  assign b_obs = {b_imem_req, b_ir_write, b_pc_write, b_reg_write, b_mem_read, b_mem_write,
                  b_branch, b_jump, b_trap, b_trap_cause, b_state, b_alu_src, b_alu_op,
                  b_reg_write_src};

  multicycle_control #(.ENABLE_M(1), .MEM_TIMEOUT(4), .CNT_W(CntWA)) dut_a (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(a_ir), .dmem_ready(a_dr),
    .trap_clear(a_tc), .imem_req(a_imem_req), .ir_write(a_ir_write), .pc_write(a_pc_write),
    .reg_write(a_reg_write), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .branch(a_branch), .jump(a_jump), .alu_src(a_alu_src), .alu_op(a_alu_op),
    .reg_write_src(a_reg_write_src), .trap(a_trap), .trap_cause(a_trap_cause),
    .state(a_state), .retired(a_retired)
  );

  multicycle_control #(.ENABLE_M(0), .MEM_TIMEOUT(0), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(b_ir), .dmem_ready(b_dr),
    .trap_clear(b_tc), .imem_req(b_imem_req), .ir_write(b_ir_write), .pc_write(b_pc_write),
    .reg_write(b_reg_write), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .branch(b_branch), .jump(b_jump), .alu_src(b_alu_src), .alu_op(b_alu_op),
    .reg_write_src(b_reg_write_src), .trap(b_trap), .trap_cause(b_trap_cause),
    .state(b_state), .retired(b_retired)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int unsigned model_ret_a = 0;
  int unsigned model_ret_b = 0;
  string       cur_name = "";
  int          obs_cycles;
  logic [4:0]  obs_exec_alu;
  logic [1:0]  obs_cause;

  localparam logic [6:0] OpcList [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                          7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                          7'b0010111};

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h, required %h", name, got, exp);
  endtask

  function automatic logic [31:0] cur_ret();
    return (sel == 0) ? {28'd0, a_retired} : b_retired;
  endfunction

  function automatic obs_t mk(input logic [2:0] st);
    obs_t o;
    o       = '0;
    o.state = st;
    o.trap  = (st == 3'd5);
    return o;
  endfunction

  // Instruction legality straight from the RV32I(M) encoding rules.
  function automatic logic is_legal(input logic [31:0] ins, input logic en_m);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (ins[6:0])
      7'b0110011: return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                         (en_m && f7 == 7'h01);
      7'b0010011: begin
        if (f3 == 3'd1) return f7 == 7'h00;
        if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
        return 1'b1;
      end
      7'b0000011: return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      7'b0100011: return f3 <= 3'd2;
      7'b1100011: return !(f3 == 3'd2 || f3 == 3'd3);
      7'b1100111: return f3 == 3'd0;
      7'b1101111, 7'b0110111, 7'b0010111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Named ALU codes: ADD SUB SLL SLT SLTU XOR SRL/SRA OR AND.
  function automatic logic [3:0] base_code(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? 4'b1000 : 4'b0000;
      3'd1: return 4'b0001;
      3'd2: return 4'b0010;
      3'd3: return 4'b0011;
      3'd4: return 4'b0100;
      3'd5: return alt ? 4'b1101 : 4'b0101;
      3'd6: return 4'b0110;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic exp_alu(input logic [31:0] ins, output logic care, output logic [1:0] src,
                         output logic [4:0] op);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    care = 1'b1;
    src  = 2'b00;
    op   = 5'b00000;
    case (ins[6:0])
      7'b0110011: op = (f7 == 7'h01) ? {2'b10, f3} : {1'b0, base_code(f3, f7 == 7'h20)};
      7'b0010011: begin
        src = 2'b01;
        op  = {1'b0, base_code(f3, f3 == 3'd5 && f7 == 7'h20)};
      end
      7'b0000011, 7'b0100011, 7'b1100111: src = 2'b01;
      7'b0010111: src = 2'b10;
      7'b1100011: op = (f3 < 3'd4) ? 5'b01000 : (f3 < 3'd6) ? 5'b00010 : 5'b00011;
      default: care = 1'b0;
    endcase
  endtask

  function automatic logic [1:0] exp_rws(input logic [6:0] opc);
    case (opc)
      7'b0000011: return 2'b01;
      7'b1101111, 7'b1100111: return 2'b10;
      7'b0110111: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // One clock cycle: drive at posedge+1, compare at negedge, return at next posedge+1.
  task automatic step(input logic ir, input logic dr, input logic tc, input logic [31:0] ins,
                      input obs_t exp, input logic care_alu, input logic care_rws);
    obs_t        got, msk;
    logic [31:0] got_ret, er;
    imem_ready_v = ir;
    dmem_ready_v = dr;
    trap_clear_v = tc;
    instr        = ins;
    @(negedge clk);
    got     = (sel == 0) ? a_obs : b_obs;
    got_ret = cur_ret();
    er      = (sel == 0) ? (model_ret_a & 32'hF) : model_ret_b;
    msk     = '1;
    if (!care_alu) begin
      msk.alu_src = '0;
      msk.alu_op  = '0;
    end
    if (!care_rws) msk.rws = '0;
    checks++;
    if (((got & msk) === (exp & msk)) && (got_ret === er)) passes++;
    else $display("FAIL %s cycle: got outputs %h retired %0d, required %h retired %0d",
                  cur_name, got & msk, got_ret, exp & msk, er);
    if (got.state == 3'd2) obs_exec_alu = got.alu_op;
    if (got.state != 3'd0) obs_cycles++;
    if (got.trap) obs_cause = got.trap_cause;
    if (exp.pc_write) begin
      if (sel == 0) model_ret_a++;
      else model_ret_b++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic trap_seq(input logic [1:0] cause, input int tw);
    obs_t e;
    e            = mk(3'd5);
    e.trap_cause = cause;
    for (int i = 0; i < tw; i++) step(rb(), rb(), 1'b0, $urandom, e, 1'b0, 1'b0);
    step(rb(), rb(), 1'b1, $urandom, e, 1'b0, 1'b0);
  endtask

  // Expected trace of one instruction, from fetch wait, memory wait and trap-clear wait.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input int tw);
    logic       en_m, ca, timeout;
    int         to, nw;
    logic [6:0] opc;
    logic [1:0] src;
    logic [4:0] op;
    obs_t       e;
    en_m = (sel == 0);
    to   = (sel == 0) ? 4 : 0;
    opc  = ins[6:0];
    obs_cycles   = 1;
    obs_exec_alu = 5'h1F;
    obs_cause    = 2'b00;
    exp_alu(ins, ca, src, op);
    e = mk(3'd0);
    e.imem_req = 1'b1;
    for (int i = 0; i < fw; i++) step(1'b0, rb(), rb(), $urandom, e, 1'b0, 1'b0);
    e.ir_write = 1'b1;
    step(1'b1, rb(), rb(), ins, e, 1'b0, 1'b0);
    step(rb(), rb(), rb(), $urandom, mk(3'd1), 1'b1, 1'b1);
    if (!is_legal(ins, en_m)) begin
      trap_seq(2'b01, tw);
      return;
    end
    e = mk(3'd2);
    e.alu_src = src;
    e.alu_op  = op;
    if (opc == 7'b1100011) begin
      e.branch   = 1'b1;
      e.pc_write = 1'b1;
      step(rb(), rb(), rb(), $urandom, e, ca, 1'b0);
      return;
    end
    step(rb(), rb(), rb(), $urandom, e, ca, 1'b0);
    if (opc == 7'b0000011 || opc == 7'b0100011) begin
      timeout = (to > 0) && (mw >= to);
      nw      = timeout ? to : mw;
      e = mk(3'd3);
      e.alu_src   = src;
      e.alu_op    = op;
      e.mem_read  = (opc == 7'b0000011);
      e.mem_write = (opc == 7'b0100011);
      for (int i = 0; i < nw; i++) step(rb(), 1'b0, rb(), $urandom, e, ca, 1'b0);
      if (timeout) begin
        trap_seq(2'b10, tw);
        return;
      end
      e.pc_write = e.mem_write;
      step(rb(), 1'b1, rb(), $urandom, e, ca, 1'b0);
      if (opc == 7'b0100011) return;
    end
    e = mk(3'd4);
    e.alu_src   = src;
    e.alu_op    = op;
    e.reg_write = 1'b1;
    e.pc_write  = 1'b1;
    e.rws       = exp_rws(opc);
    e.jump      = (opc == 7'b1101111) || (opc == 7'b1100111);
    step(rb(), rb(), rb(), $urandom, e, ca, 1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  f7;
    r = $urandom;
    if ($urandom_range(9, 0) != 0) r[6:0] = OpcList[$urandom_range(8, 0)];
    case ($urandom_range(3, 0))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    r[31:25] = f7;
    return r;
  endfunction

  typedef struct {
    string       name;
    logic [31:0] ins;
    int          sel_i;
    int          mw;
    logic [4:0]  alu;
    int          cycles;
    int          inc;
    logic [1:0]  cause;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] r0, dlt;
    vecs.push_back(vec_t'{"add",       32'h002081B3, 0, 0,  5'h00, 4,  1, 2'b00});
    vecs.push_back(vec_t'{"lw_wait3",  32'h0000A103, 0, 3,  5'h00, 8,  1, 2'b00});
    vecs.push_back(vec_t'{"mul_en",    32'h022081B3, 0, 0,  5'h10, 4,  1, 2'b00});
    vecs.push_back(vec_t'{"mul_dis",   32'h022081B3, 1, 0,  5'h1F, 3,  0, 2'b01});
    vecs.push_back(vec_t'{"sw_tmo",    32'h0020A023, 0, 10, 5'h00, 8,  0, 2'b10});
    vecs.push_back(vec_t'{"sw_edge",   32'h0020A023, 0, 3,  5'h00, 7,  1, 2'b00});
    vecs.push_back(vec_t'{"sw_no_tmo", 32'h0020A023, 1, 10, 5'h00, 14, 1, 2'b00});
    vecs.push_back(vec_t'{"beq",       32'h00208463, 0, 0,  5'h08, 3,  1, 2'b00});
    vecs.push_back(vec_t'{"bltu",      32'h0020E463, 1, 0,  5'h03, 3,  1, 2'b00});
    vecs.push_back(vec_t'{"sub",       32'h402081B3, 1, 0,  5'h08, 4,  1, 2'b00});
    vecs.push_back(vec_t'{"srai",      32'h4020D093, 0, 0,  5'h0D, 4,  1, 2'b00});
    vecs.push_back(vec_t'{"jalr",      32'h000080E7, 0, 0,  5'h00, 4,  1, 2'b00});
    vecs.push_back(vec_t'{"jalr_f3",   32'h000090E7, 0, 0,  5'h1F, 3,  0, 2'b01});
    vecs.push_back(vec_t'{"ld_rv64",   32'h0000B103, 1, 0,  5'h1F, 3,  0, 2'b01});
    vecs.push_back(vec_t'{"bad_opc",   32'h00000000, 0, 0,  5'h1F, 3,  0, 2'b01});

    #1 rst = 1'b1;
    #2;
    chk("reset_outputs_a", 32'(a_obs), 32'd0);
    chk("reset_outputs_b", 32'(b_obs), 32'd0);
    chk("reset_retired_a", {28'd0, a_retired}, 32'd0);
    chk("reset_retired_b", b_retired, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      sel      = vecs[i].sel_i;
      cur_name = vecs[i].name;
      r0       = cur_ret();
      run_instr(vecs[i].ins, 0, vecs[i].mw, 0);
      dlt = cur_ret() - r0;
      if (sel == 0) dlt = dlt & 32'hF;
      chk({vecs[i].name, "_cycles"}, obs_cycles, vecs[i].cycles);
      chk({vecs[i].name, "_exec_alu_op"}, {27'd0, obs_exec_alu}, {27'd0, vecs[i].alu});
      chk({vecs[i].name, "_trap_cause"}, {30'd0, obs_cause}, {30'd0, vecs[i].cause});
      chk({vecs[i].name, "_retired_delta"}, dlt, vecs[i].inc);
    end

    // Reset asserted mid-MEM on a load that is still waiting.
    sel      = 0;
    cur_name = "rst_mid_mem";
    run_instr(32'h002081B3, 0, 0, 0);
    if ((model_ret_a & 32'hF) == 0) run_instr(32'h002081B3, 0, 0, 0);
    begin
      obs_t e;
      e = mk(3'd0);
      e.imem_req = 1'b1;
      e.ir_write = 1'b1;
      step(1'b1, 1'b0, 1'b0, 32'h0000A103, e, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, mk(3'd1), 1'b1, 1'b1);
      e = mk(3'd2);
      e.alu_src = 2'b01;
      step(1'b0, 1'b0, 1'b0, 32'h0, e, 1'b1, 1'b0);
      e = mk(3'd3);
      e.alu_src  = 2'b01;
      e.mem_read = 1'b1;
      step(1'b0, 1'b0, 1'b0, 32'h0, e, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, e, 1'b1, 1'b0);
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_mem_read_drop", {31'd0, a_mem_read}, 32'd0);
    chk("rst_state", {29'd0, a_state}, 32'd0);
    chk("rst_retired", {28'd0, a_retired}, 32'd0);
    chk("rst_no_imem_req", {31'd0, a_imem_req}, 32'd0);
    chk("rst_all_outputs", 32'(a_obs), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_ret_a = 0;
    model_ret_b = 0;
    #1;
    chk("first_imem_req_after_rst", {31'd0, a_imem_req}, 32'd1);
    run_instr(32'h0000A103, 0, 1, 0);

    cur_name = "random";
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(1, 0));
      run_instr(rand_instr(), int'($urandom_range(2, 0)), int'($urandom_range(6, 0)),
                int'($urandom_range(2, 0)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter ENABLE_M, default 0, meaning 1 decodes the RV32M ops (funct7=0000001); 0 treats them as illegal.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 0, meaning the maximum MEM-state wait cycles before a trap; 0 means no timeout.
REQ-003 SHALL have parameter CNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-004 SHALL use a single clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-005 Ports:
  clk  in  1  clock, rising edge
  rst  in  1  async active-high reset
  instr  in  32  instruction word, valid when imem_ready=1 in FETCH
  imem_ready  in  1  instruction fetch complete
  dmem_ready  in  1  data access complete
  trap_clear  in  1  leave TRAP
  imem_req  out  1  fetch request
  ir_write  out  1  latch instruction register
  pc_write  out  1  update PC (PC+4, or target when branch/jump)
  reg_write  out  1  register file write strobe
  mem_read  out  1  data read request
  mem_write  out  1  data write request
  branch  out  1  branch instruction in EXECUTE
  jump  out  1  JAL/JALR in WB
  alu_src  out  2  00 reg, 01 imm, 10 PC
  alu_op  out  5  ALU operation
  reg_write_src  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm
  trap  out  1  in TRAP
  trap_cause  out  2  01 illegal, 10 mem timeout
  state  out  3  current state encoding
  retired  out  CNT_W  completed-instruction count

Function
REQ-006 SHALL implement the states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 SHALL go to FETCH on the next edge.
REQ-007 FETCH SHALL assert imem_req; on imem_ready it SHALL assert ir_write in the same cycle, latch instr[31:0] into the internal opcode/funct3/funct7 fields, and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-008 DECODE SHALL check legality from the latched fields only and go to TRAP with trap_cause=01 if illegal, else to EXECUTE; outputs stay 0 in DECODE.
REQ-009 The instruction SHALL be illegal when any of the following holds:
  - opcode is not one of the 9 RV32I opcodes (R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - R-type funct7 is not 0000000, nor 0100000 with funct3 000/101, nor (ENABLE_M and 0000001);
  - I-type shift with funct7 other than 0000000 (or 0100000 for funct3=101);
  - LOAD funct3 is 011, 110 or 111;
  - STORE funct3 is greater than 010;
  - BRANCH funct3 is 010 or 011;
  - JALR funct3 is not 000.
REQ-010 alu_op SHALL be {1'b0, code} for base operations, with code ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
REQ-011 For M ops, alu_op SHALL be {2'b10, funct3}.
REQ-012 EXECUTE SHALL drive alu_src and alu_op per opcode: R reg; I/LOAD/STORE/JALR imm with ADD for LOAD/STORE/JALR; AUIPC PC/ADD; BRANCH reg with SUB (BEQ/BNE), SLT (BLT/BGE), SLTU (BLTU/BGEU).
REQ-013 From EXECUTE, LOAD/STORE SHALL go to MEM; BRANCH SHALL assert branch and pc_write for one cycle and go to FETCH; all other opcodes SHALL go to WB.
REQ-014 alu_src and alu_op SHALL be held from EXECUTE through MEM and WB.
REQ-015 MEM SHALL hold mem_read (LOAD) or mem_write (STORE) every cycle until dmem_ready; on dmem_ready a LOAD SHALL go to WB, and a STORE SHALL assert pc_write and go to FETCH.
REQ-016 When MEM_TIMEOUT>0, a wait counter SHALL be cleared on MEM entry and increment each MEM cycle without dmem_ready; when it reaches MEM_TIMEOUT, the block SHALL go to TRAP with trap_cause=10.
REQ-017 If dmem_ready arrives in the same cycle the counter reaches MEM_TIMEOUT, dmem_ready SHALL take priority.
REQ-018 WB SHALL assert reg_write and pc_write for exactly one cycle and set reg_write_src to 00 (R/I/AUIPC), 01 (LOAD), 10 (JAL/JALR, with jump=1) or 11 (LUI), then go to FETCH.
REQ-019 retired SHALL increment by 1, wrapping at 2^CNT_W, on every cycle where pc_write=1.
REQ-020 TRAP SHALL hold trap=1 and trap_cause, with all strobes at 0; on trap_clear it SHALL go to FETCH and clear trap_cause to 00 on the same edge.
REQ-021 trap_clear SHALL be ignored outside TRAP.
REQ-022 Strobe outputs (imem_req, ir_write, pc_write, reg_write, mem_read, mem_write, branch, jump) SHALL be combinational from state and the latched fields, and SHALL never be asserted in states where this section does not assert them.

Reset
REQ-023 While rst=1, asynchronously: state=FETCH, retired=0, latched fields=0, wait counter=0, trap_cause=00.
REQ-024 While rst=1, all strobes SHALL be 0 (imem_req included) and alu_src=00, alu_op=00000, reg_write_src=00.
REQ-025 Reset asserted in any state, including mid-MEM, SHALL abort the instruction with no further strobes.
REQ-026 The first imem_req SHALL appear in the first cycle after rst deasserts.

Verification
REQ-027 ADD 0x002081B3, imem_ready=1 -> the FETCH, DECODE, EXECUTE, WB sequence completes in 4 cycles, with alu_op=00000 and reg_write=1 in WB, and retired goes 0 to 1.
REQ-028 LW 0x0000A103 with dmem_ready low for 3 MEM cycles -> mem_read is high for 4 cycles, then WB with reg_write_src=01.
REQ-029 MUL 0x022081B3 -> with ENABLE_M=1, alu_op=10000 and completion in WB; with ENABLE_M=0, TRAP with trap_cause=01 and retired unchanged.
REQ-030 SW 0x0020A023 with MEM_TIMEOUT=4 and dmem_ready held low -> 4 MEM cycles with mem_write=1, then TRAP with trap_cause=10; trap_clear -> FETCH.
REQ-031 BEQ 0x00208463 -> in EXECUTE, branch=1, pc_write=1 and alu_op=01000, with no WB and reg_write never asserted.
REQ-032 rst pulsed mid-MEM during an LW -> mem_read drops immediately, state=0, retired=0, and the next fetch starts after release.
